// File: rtl/vga_timing_gen.sv
// Video timing generator: cascaded horizontal/vertical counters with sync, display-enable,
// line/frame strobes and a frame counter, all registered and coherent with x/y.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int FCW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0]  x_nxt;
  logic [CW-1:0]  y_nxt;
  logic [FCW-1:0] fc_nxt;
  logic           hs_nxt;
  logic           vs_nxt;
  logic           de_nxt;
  logic           ls_nxt;
  logic           fs_nxt;

  // Decode is taken from the next-state counters so every output lands in the same
  // register stage as x/y, with no extra latency between position and sync/enable.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    x_nxt  = x;
    y_nxt  = y;
    fc_nxt = frame_count;

    if (x == H_LAST) begin
      x_nxt = '0;
      if (y == V_LAST) begin
        y_nxt  = '0;
        fc_nxt = frame_count + FCW'(1);
      end else begin
        y_nxt = y + CW'(1);
      end
    end else begin
      x_nxt = x + CW'(1);
    end

    hs_nxt = (int'(x_nxt) >= HS_START && int'(x_nxt) < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    vs_nxt = (int'(y_nxt) >= VS_START && int'(y_nxt) < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    de_nxt = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
    ls_nxt = (x_nxt == '0);
    fs_nxt = (x_nxt == '0) && (y_nxt == '0);
  end

  // Reset state is the decode of position (0,0); a stalled strobe simply keeps its value.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      x           <= '0;
      y           <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      frame_count <= '0;
    end else if (en) begin
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      de          <= de_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      frame_count <= fc_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations driven with random clock
// enables and compared each cycle against an arithmetic position model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint x, y, hs, vs, de, ls, fs, fc;
  } exp_t;

  // Position is a pure function of how many enabled edges have elapsed since reset release.
  function automatic exp_t ref_model(input longint t, input int ha, hf, hw, hb,
                                     input int va, vf, vw, vb, input int hp, vp, fcw);
    exp_t   e;
    longint ht, vt, line;
    ht     = ha + hf + hw + hb;
    vt     = va + vf + vw + vb;
    e.x    = t % ht;
    line   = t / ht;
    e.y    = line % vt;
    e.fc   = (line / vt) % (64'd1 << fcw);
    e.hs   = (e.x >= ha + hf && e.x < ha + hf + hw) ? hp : 1 - hp;
    e.vs   = (e.y >= va + vf && e.y < va + vf + vw) ? vp : 1 - vp;
    e.de   = (e.x < ha && e.y < va) ? 1 : 0;
    e.ls   = (e.x == 0) ? 1 : 0;
    e.fs   = (e.x == 0 && e.y == 0) ? 1 : 0;
    return e;
  endfunction

  // Instance A: default 640x480 timing.
  logic        rst_a, en_a;
  logic [9:0]  x_a, y_a;
  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [15:0] fc_a;
  longint      t_a = 0;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  // Instance B: default horizontal timing, short frame so wraps are reachable.
  logic        rst_b, en_b;
  logic [9:0]  x_b, y_b;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;
  logic [15:0] fc_b;
  longint      t_b = 0;

  vga_timing_gen #(.V_ACTIVE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  // Instance C: tiny timing, active-high syncs, 4-bit frame counter.
  logic       rst_c, en_c;
  logic [3:0] x_c, y_c;
  logic       hs_c, vs_c, de_c, ls_c, fs_c;
  logic [3:0] fc_c;
  longint     t_c = 0;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4), .FCW(4)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .x(x_c), .y(y_c), .hsync(hs_c), .vsync(vs_c),
    .de(de_c), .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  task automatic cmp_a(input string p);
    exp_t e;
    e = ref_model(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16);
    check({p, ".x"}, x_a, e.x);   check({p, ".y"}, y_a, e.y);
    check({p, ".hs"}, hs_a, e.hs); check({p, ".vs"}, vs_a, e.vs);
    check({p, ".de"}, de_a, e.de); check({p, ".ls"}, ls_a, e.ls);
    check({p, ".fs"}, fs_a, e.fs); check({p, ".fc"}, fc_a, e.fc);
  endtask

  task automatic cmp_b(input string p);
    exp_t e;
    e = ref_model(t_b, 640, 16, 96, 48, 4, 2, 2, 3, 0, 0, 16);
    check({p, ".x"}, x_b, e.x);   check({p, ".y"}, y_b, e.y);
    check({p, ".hs"}, hs_b, e.hs); check({p, ".vs"}, vs_b, e.vs);
    check({p, ".de"}, de_b, e.de); check({p, ".ls"}, ls_b, e.ls);
    check({p, ".fs"}, fs_b, e.fs); check({p, ".fc"}, fc_b, e.fc);
  endtask

  task automatic cmp_c(input string p);
    exp_t e;
    e = ref_model(t_c, 4, 1, 1, 1, 2, 1, 1, 1, 1, 1, 4);
    check({p, ".x"}, x_c, e.x);   check({p, ".y"}, y_c, e.y);
    check({p, ".hs"}, hs_c, e.hs); check({p, ".vs"}, vs_c, e.vs);
    check({p, ".de"}, de_c, e.de); check({p, ".ls"}, ls_c, e.ls);
    check({p, ".fs"}, fs_c, e.fs); check({p, ".fc"}, fc_c, e.fc);
  endtask

  task automatic step_a(input bit e);
    en_a = e; @(posedge clk); if (e) t_a++; #1; cmp_a("A");
  endtask
  task automatic step_b(input bit e);
    en_b = e; @(posedge clk); if (e) t_b++; #1; cmp_b("B");
  endtask
  task automatic step_c(input bit e);
    en_c = e; @(posedge clk); if (e) t_c++; #1; cmp_c("C");
  endtask

  function automatic bit rand_en();
    return $urandom_range(0, 3) != 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int de_cnt, hs_low, ls_cnt, budget;
    bit e;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b1;  en_b = 1'b1;  en_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_a("A.rst");
    check("A.rst_hsync", hs_a, 1);
    check("A.rst_vsync", vs_a, 1);

    // Release and first enabled edge.
    rst_a = 1'b0;
    step_a(1'b1);
    check("A.first_x", x_a, 1);

    // Reset asserted mid-line: outputs must drop back immediately, before any edge.
    repeat (300) step_a(1'b1);
    #2 rst_a = 1'b1;
    #1 t_a = 0;
    cmp_a("A.rst_mid");
    @(posedge clk); #1;
    cmp_a("A.rst_hold");
    rst_a = 1'b0;

    // Three full lines with random stalls; tally per visited position.
    de_cnt = 0; hs_low = 0; ls_cnt = 0; budget = 0;
    while (t_a < 2400 && budget < 6000) begin
      e = rand_en();
      step_a(e);
      budget++;
      if (e) begin
        de_cnt += int'(de_a);
        hs_low += int'(!hs_a);
        ls_cnt += int'(ls_a);
      end
    end
    check("A.line_budget", t_a, 2400);
    check("A.de_count", de_cnt, 3 * 640);
    check("A.hsync_low_count", hs_low, 3 * 96);
    check("A.line_start_count", ls_cnt, 3);

    // Stall just before hsync begins.
    while (t_a % 800 != 655) step_a(1'b1);
    repeat (5) begin
      step_a(1'b0);
      check("A.stall_x", x_a, 655);
      check("A.stall_hsync", hs_a, 1);
    end
    step_a(1'b1);
    check("A.resume_x", x_a, 656);
    check("A.resume_hsync", hs_a, 0);

    // Instance B: first frame with random stalls up to the wrap point.
    #1 rst_b = 1'b0;
    budget = 0;
    while (t_b < 8800 && budget < 20000) begin
      e = rand_en();
      step_b(e);
      budget++;
      if (e && t_b == 4 * 800) begin
        check("B.vblank_y", y_b, 4);
        check("B.vblank_de", de_b, 0);
      end
    end
    check("B.frame_budget", t_b, 8800);
    check("B.wrap_x", x_b, 0);
    check("B.wrap_y", y_b, 0);
    check("B.wrap_fs", fs_b, 1);
    check("B.wrap_fc", fc_b, 1);
    repeat (4) begin
      step_b(1'b0);
      check("B.hold_fs", fs_b, 1);
      check("B.hold_fc", fc_b, 1);
    end
    step_b(1'b1);
    check("B.after_fs", fs_b, 0);
    check("B.after_fc", fc_b, 1);
    budget = 0;
    while (t_b < 2 * 8800 + 1600 && budget < 20000) begin
      step_b(rand_en());
      budget++;
    end
    check("B.second_budget", t_b, 2 * 8800 + 1600);

    // Instance C: polarity and 4-bit frame counter wrap.
    #1 rst_c = 1'b0;
    budget = 0;
    while (t_c < 525 && budget < 2000) begin
      step_c(rand_en());
      budget++;
    end
    check("C.budget", t_c, 525);
    check("C.fc_15", fc_c, 15);
    repeat (35) step_c(1'b1);
    check("C.fc_wrap", fc_c, 0);
    check("C.wrap_fs", fs_c, 1);
    repeat (5) step_c(1'b1);
    check("C.hsync_active_high", hs_c, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
